// File: rtl/route_arbiter.sv
// Round-robin route arbiter for one NoC output port; the grant is held for a whole packet.
// Optional watchdog on stalled reservations: define ROUTE_ARB_WATCHDOG_EN.
module route_arbiter #(
  parameter int N           = 4,
  parameter int INDEX_WIDTH = $clog2(N),
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           reserveRoute,
  input  logic [N-1:0]           routeRelieve,
  input  logic [N-1:0]           Handshake,
  output logic [N-1:0]           routeReserveStatus,
  output logic [N-1:0]           grant,
  output logic [INDEX_WIDTH-1:0] grantIndex,
  output logic                   grantValid
`ifdef ROUTE_ARB_WATCHDOG_EN
  ,
  output logic                   stallErr
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] ptr;
  logic [INDEX_WIDTH-1:0] win_idx;
  logic [INDEX_WIDTH-1:0] next_ptr;
  logic [N-1:0]           win_oh;
  logic                   win_any;
  logic                   owner_rel;

  // Winner = set bit with the smallest upward distance from the pointer.
  always_comb begin
    int best;
    int d;
    best    = N;
    d       = 0;
    win_idx = '0;
    for (int k = 0; k < N; k++) begin
      d = k - int'(ptr);
      if (d < 0) d = d + N;
      if (reserveRoute[k] && d < best) begin
        best    = d;
        win_idx = INDEX_WIDTH'(k);
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int k = 0; k < N; k++)
      win_oh[k] = (win_idx == INDEX_WIDTH'(k));
  end

  assign win_any   = |reserveRoute;
  assign owner_rel = routeRelieve[grantIndex];
  assign next_ptr  = (grantIndex == INDEX_WIDTH'(N-1)) ? '0 : grantIndex + INDEX_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      ptr                <= '0;
      grant              <= '0;
      grantIndex         <= '0;
      grantValid         <= 1'b0;
      routeReserveStatus <= '0;
    end else begin
      routeReserveStatus <= '0;
      case (state)
        IDLE: begin
          if (win_any) begin
            state              <= GRANT;
            grant              <= win_oh;
            grantIndex         <= win_idx;
            grantValid         <= 1'b1;
            routeReserveStatus <= win_oh;
          end
        end
        GRANT, LOCKED: begin
          // Only the owner's relieve ends the reservation; the pointer moves past it.
          if (owner_rel) begin
            state      <= IDLE;
            grant      <= '0;
            grantValid <= 1'b0;
            ptr        <= next_ptr;
          end else begin
            state <= LOCKED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTE_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;

  // Counts locked cycles without an owner handshake; saturates at TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt   <= '0;
      stallErr <= 1'b0;
    end else if (state == LOCKED && !owner_rel && !Handshake[grantIndex]) begin
      if (wd_cnt != CW'(TIMEOUT)) wd_cnt <= wd_cnt + CW'(1);
      if (wd_cnt == CW'(TIMEOUT - 1)) stallErr <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^{Handshake, (TIMEOUT != 0)};
`endif

endmodule

// File: tb/tb_route_arbiter.sv
// Randomized + directed bench for route_arbiter against a reservation-level reference model.
module tb_route_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0, rel = '0, hs = '0;
  logic [N-1:0]  status, grant;
  logic [IW-1:0] gidx;
  logic          gvalid;
`ifdef ROUTE_ARB_WATCHDOG_EN
  logic          stall;
`endif

  int n_chk = 0, n_bad = 0;

  // reference model: who owns the port, whether this is its first cycle, where the pointer is
  int m_owner = -1, m_ptr = 0, m_stale = 0;
  bit m_fresh = 0, m_stall = 0;
  int order[$];

  always #5 clk = ~clk;

  route_arbiter #(.N(N), .INDEX_WIDTH(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .reserveRoute(req), .routeRelieve(rel), .Handshake(hs),
    .routeReserveStatus(status), .grant(grant),
    .grantIndex(gidx), .grantValid(gvalid)
`ifdef ROUTE_ARB_WATCHDOG_EN
    , .stallErr(stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_owner = -1; m_ptr = 0; m_fresh = 0; m_stale = 0; m_stall = 0;
  endfunction

  function automatic void m_edge(logic [N-1:0] r, logic [N-1:0] rl, logic [N-1:0] h);
    if (m_owner < 0) begin
      m_fresh = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && r[c]) begin m_owner = c; m_fresh = 1; m_stale = 0; end
      end
    end else if (rl[m_owner]) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_fresh = 0; m_stale = 0;
    end else begin
      if (!m_fresh) begin
        if (h[m_owner]) m_stale = 0;
        else if (m_stale < TO) m_stale++;
        if (m_stale == TO) m_stall = 1;
      end
      m_fresh = 0;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    m_edge(req, rel, hs);
    #1;
    chk("grantValid", gvalid, m_owner >= 0);
    chk("grant", grant, (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("status", status, m_fresh ? (1 << m_owner) : 0);
    if (m_owner >= 0) chk("grantIndex", gidx, m_owner);
    if (status != 0) order.push_back(int'(gidx));
`ifdef ROUTE_ARB_WATCHDOG_EN
    chk("stallErr", stall, m_stall);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; rel = '0; hs = '0;
    m_reset();
    #2 rst = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b0;
    #11;
    chk("rst_status", status, 0);
    chk("rst_grant", grant, 0);
    chk("rst_valid", gvalid, 0);
    chk("rst_index", gidx, 0);
    rst = 1'b1;
    m_reset();
    cyc();

    // single request on port 2
    req = 4'b0100; cyc();
    chk("single_status", status, 4'b0100);
    chk("single_idx", gidx, 2);
    req = '0; cyc();
    chk("single_pulse_end", status, 0);
    cyc(); cyc();
    rel = 4'b0100; cyc(); rel = '0;
    chk("single_release", gvalid, 0);

    // wrap-around: pointer now 3
    req = 4'b0011; cyc();
    chk("wrap_first", gidx, 0);
    req = 4'b0010; cyc(); cyc();
    rel = 4'b0001; cyc(); rel = '0;
    chk("wrap_gap", gvalid, 0);
    cyc();
    chk("wrap_second", gidx, 1);
    chk("wrap_second_v", gvalid, 1);

    // stray relieve and dropped request while port 1 holds the port
    req = '0; cyc();
    rel = 4'b0001; cyc(); rel = '0;
    chk("stray_hold", grant, 4'b0010);
    cyc();
    rel = 4'b0010; cyc(); rel = '0;

    // relieve during the GRANT cycle
    req = 4'b0010; cyc();
    req = '0; rel = 4'b0010; cyc(); rel = '0;
    chk("grant_cycle_release", gvalid, 0);
    cyc();

    // asynchronous reset while port 2 is locked
    req = 4'b0100; cyc(); req = '0; cyc(); cyc();
    #2 rst = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_valid", gvalid, 0);
    chk("arst_index", gidx, 0);
    m_reset();
    #2 rst = 1'b1;
    req = 4'b1100; cyc();
    chk("arst_ptr", gidx, 2);
    req = 4'b1000; rel = 4'b0100; cyc(); rel = '0;

    // fairness: all ports requesting, release 5 cycles after each grant
    do_reset();
    order.delete();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int w;
      w = 0;
      cyc();
      while (status == 0 && w < 10) begin cyc(); w++; end
      chk("fair_grant_seen", status != 0, 1);
      repeat (4) cyc();
      rel = 4'b0001 << gidx; cyc(); rel = '0;
    end
    begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      chk("fair_count", order.size(), 5);
      for (int i = 0; i < 5 && i < order.size(); i++)
        chk("fair_order", order[i], exp_order[i]);
    end
    req = '0;

`ifdef ROUTE_ARB_WATCHDOG_EN
    // watchdog: no handshake while locked
    do_reset();
    req = 4'b0001; cyc(); req = '0;
    repeat (TO + 1) cyc();
    chk("wd_stall_set", stall, 1);
    rel = 4'b0001; cyc(); rel = '0; cyc();
    chk("wd_stall_sticky", stall, 1);
    // handshake every 4 cycles keeps it quiet
    do_reset();
    req = 4'b0001; cyc(); req = '0;
    for (int i = 0; i < 30; i++) begin
      hs = (i % 4 == 0) ? 4'b0001 : 4'b0000;
      cyc();
    end
    hs = '0;
    chk("wd_stall_quiet", stall, 0);
    rel = 4'b0001; cyc(); rel = '0;
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req = N'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 4) == 0) rel = 4'b0001 << m_owner;
      else rel = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      hs = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/route_arbiter.md
# route_arbiter

Per-output-port route arbiter for the NoC router: shares one output port between `N` input-port `ControlFSM` instances. It grants one requester at a time in round-robin order and holds that reservation for the whole packet until the owner signals release on its tail flit. The `reserveRoute` / `routeReserveStatus` / `routeRelieve` signals of each input port connect here.

## Interface
- `N`, default 4: number of input ports competing for this output port (N ≥ 2; need not be a power of two).
- `INDEX_WIDTH`, default `$clog2(N)`: width of the granted-index output.
- `TIMEOUT`, default 64: watchdog limit in cycles (used only with the macro).

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `reserveRoute`  in  N: per-port route request, level; held by the requester until it sees its status pulse.
- `routeRelieve`  in  N: per-port release; a one-cycle pulse on the tail-flit transfer.
- `Handshake`  in  N: per-port flit-transfer strobe; used only by the watchdog.
- `routeReserveStatus`  out  N: one-hot, one-cycle pulse telling the winner its route is reserved.
- `grant`  out  N: one-hot ownership, held for the whole reservation; drives the crossbar select.
- `grantIndex`  out  INDEX_WIDTH: binary index of the owner; valid while `grantValid`=1.
- `grantValid`  out  1: output port is reserved.
- `stallErr`  out  1: sticky watchdog error; present only with `ROUTE_ARB_WATCHDOG_EN`.

## Operation
- Reset values: `routeReserveStatus`=0, `grant`=0, `grantIndex`=0, `grantValid`=0, `stallErr`=0. Internally, the priority pointer is 0 and the state is IDLE.
- State IDLE:
  - Samples `reserveRoute`.
  - If any bit is set, it picks the first set bit at or after the pointer, searching upward and wrapping N-1→0.
  - The winner is registered into `grant` and `grantIndex`, and the state moves to GRANT.
  - If no bit is set, the state stays IDLE.
- State GRANT (one cycle):
  - `routeReserveStatus[w]`=1, `grant[w]`=1, `grantValid`=1.
  - Next state is LOCKED.
  - If `routeRelieve[w]` is also set in this cycle (single-flit packet), the next state is IDLE instead.
- State LOCKED:
  - Holds `grant` and `grantValid`.
  - `routeRelieve[w]`=1 moves the state to IDLE, clears the grant, and sets the pointer to (w+1) mod N.
- Ignored inputs:
  - `routeRelieve` bits from non-owners are ignored in every state.
  - The owner dropping `reserveRoute` while locked does not release the port; only `routeRelieve` does.
  - Requests arriving during GRANT or LOCKED are not queued; they are re-evaluated in the next IDLE.
- The pointer advances only on release, never on grant. This guarantees each of N continuously requesting ports is served within N reservations.
- Reset mid-reservation: all outputs clear immediately (asynchronously), and the pointer returns to 0. A `ControlFSM` that is still waiting must re-request.

## Timing
- Request seen in IDLE at edge t: `grant`, `grantValid` and `routeReserveStatus` are high after edge t+1. `routeReserveStatus` is low again after edge t+2.
- Release pulse sampled at edge t: `grant` and `grantValid` are low after edge t+1. The earliest next grant is after edge t+2, so the port has one idle cycle between packets.
- Minimum reservation length is 1 cycle of `grantValid` (relieve during GRANT).
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `ROUTE_ARB_WATCHDOG_EN` defined:
  - A counter of width `$clog2(TIMEOUT+1)` clears on GRANT and on every `Handshake[w]` in LOCKED, and increments otherwise while LOCKED.
  - When it reaches `TIMEOUT`, `stallErr` goes to 1 and stays set until reset. The reservation is not released.
  - The counter saturates and clears on return to IDLE.
- Macro undefined: no counter and no `stallErr` port. All other behaviour is identical.

## Test plan
- Single request: `reserveRoute`=4'b0100 in IDLE → `routeReserveStatus`=4'b0100 for exactly one cycle, `grantIndex`=2, `grant` held until `routeRelieve`=4'b0100 → `grantValid`=0 one cycle later.
- Round-robin fairness: `reserveRoute`=4'b1111 held, with release 5 cycles after each grant → grant order 0,1,2,3,0 and one idle cycle between grants.
- Wrap-around with gaps: pointer=3, `reserveRoute`=4'b0011 → port 0 granted; after release, port 1 granted.
- Stray and simultaneous inputs: while port 1 is locked, `routeRelieve`=4'b0001 and port 1 dropping `reserveRoute` → lock held. `routeRelieve[1]` during the GRANT cycle → back to IDLE after one cycle.
- Reset mid-lock: drive `rst`=0 asynchronously while port 2 is locked → all outputs 0 immediately. After reset release, `reserveRoute`=4'b1100 → port 2 granted (pointer back at 0).
- Watchdog (macro on, `TIMEOUT`=8): lock port 0, no `Handshake` for 8 cycles → `stallErr`=1, stays 1 after release. Handshake every 4 cycles → `stallErr` stays 0.
